cascade_stage_evaluator: RTL

CASCADE_STAGE_EVALUATOR -- requirements
Module: cascade_stage_evaluator

---
 rtl/haar_pkg.sv | 33 +++
 rtl/classifier_param_fetch.sv | 64 ++++++
 rtl/cascade_stage_evaluator.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/haar_pkg.sv
// ============================================================================
// Module      : haar_pkg
// Description : Shared types and constants for the Haar cascade stage evaluator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package haar_pkg;

    localparam int NUM_PARAM_PER_CLASSIFIER_DEF = 18;

    // Word offsets inside one classifier's parameter block
    localparam int OFF_RECT0     = 0;
    localparam int OFF_RECT1     = 4;
    localparam int OFF_RECT2     = 8;
    localparam int OFF_WEIGHT0   = 12;
    localparam int OFF_WEIGHT1   = 13;
    localparam int OFF_WEIGHT2   = 14;
    localparam int OFF_THRESHOLD = 15;
    localparam int OFF_LEFT      = 16;
    localparam int OFF_RIGHT     = 17;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_WAIT_WEAK = 3'd2,
        ST_COMPARE   = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/classifier_param_fetch.sv
// ============================================================================
// Module      : classifier_param_fetch
// Description : Walks one classifier's ROM block and captures each word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module classifier_param_fetch #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PARAM  = 18,
    parameter int CNT_W      = 7
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            fetch_en,
    input  logic [ADDR_WIDTH-1:0]           base,
    input  logic [CNT_W-1:0]                cls_idx,
    output logic [ADDR_WIDTH-1:0]           rom_address,
    input  logic [DATA_WIDTH-1:0]           rom_q,
    output logic [NUM_PARAM*DATA_WIDTH-1:0] params,
    output logic                            fetch_last
);

    localparam int P_W = $clog2(NUM_PARAM + 1);
    localparam logic [P_W-1:0]        C_P_LAST = P_W'(NUM_PARAM);
    localparam logic [ADDR_WIDTH-1:0] C_STRIDE = ADDR_WIDTH'(NUM_PARAM);

    logic [P_W-1:0]        p;
    logic [ADDR_WIDTH-1:0] cls_off;

    // Truncation to ADDR_WIDTH gives the required modulo wrap
    assign cls_off     = ADDR_WIDTH'(cls_idx) * C_STRIDE;
    assign rom_address = base + cls_off + ADDR_WIDTH'(p);
    assign fetch_last  = fetch_en && (p == C_P_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p <= '0;
        end else if (!fetch_en) begin
            p <= '0;
        end else if (p != C_P_LAST) begin
            p <= p + 1'b1;
        end
    end

    // Word p arrives while the counter already points at p+1
    generate
        for (genvar i = 0; i < NUM_PARAM; i++) begin : g_word
            logic [DATA_WIDTH-1:0] word;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    word <= '0;
                end else if (fetch_en && (p == P_W'(i + 1))) begin
                    word <= rom_q;
                end
            end
            assign params[i*DATA_WIDTH +: DATA_WIDTH] = word;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/cascade_stage_evaluator.sv
// ============================================================================
// Module      : cascade_stage_evaluator
// Description : Sequences one cascade stage: fetch params, sum weak values,
//               compare against stage threshold. Optional macro CASCADE_SAT_EN
//               selects a saturating accumulator instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cascade_stage_evaluator
    import haar_pkg::*;
#(
    parameter  int ADDR_WIDTH               = 10,
    parameter  int DATA_WIDTH               = 8,
    parameter  int SUM_WIDTH                = 16,
    parameter  int NUM_PARAM_PER_CLASSIFIER = NUM_PARAM_PER_CLASSIFIER_DEF,
    parameter  int MAX_CLASSIFIERS          = 64,
    localparam int CNT_W                    = $clog2(MAX_CLASSIFIERS + 1)
) (
    input  logic                                           clk_fpga,
    input  logic                                           reset_fpga,
    input  logic                                           i_start,
    input  logic [ADDR_WIDTH-1:0]                          i_stage_base_addr,
    input  logic [CNT_W-1:0]                               i_num_classifiers,
    input  logic signed [SUM_WIDTH-1:0]                    i_stage_threshold,
    output logic [ADDR_WIDTH-1:0]                          o_rom_address,
    input  logic [DATA_WIDTH-1:0]                          i_rom_q,
    output logic                                           o_param_valid,
    output logic [NUM_PARAM_PER_CLASSIFIER*DATA_WIDTH-1:0] o_params,
    input  logic                                           i_weak_valid,
    input  logic signed [SUM_WIDTH-1:0]                    i_weak_value,
    output logic                                           o_busy,
    output logic                                           o_done,
    output logic                                           o_pass,
    output logic signed [SUM_WIDTH-1:0]                    o_stage_sum
);

    localparam logic [CNT_W-1:0] C_MAX_CLS = CNT_W'(MAX_CLASSIFIERS);

    state_t                      state;
    state_t                      next_state;
    logic [ADDR_WIDTH-1:0]       base;
    logic [CNT_W-1:0]            count;
    logic [CNT_W-1:0]            idx;
    logic [CNT_W-1:0]            idx_next;
    logic [CNT_W-1:0]            count_clamped;
    logic signed [SUM_WIDTH-1:0] thresh;
    logic signed [SUM_WIDTH-1:0] acc;
    logic signed [SUM_WIDTH-1:0] acc_next;
    logic                        pass;
    logic                        fetch_en;
    logic                        fetch_last;

    assign count_clamped = (i_num_classifiers > C_MAX_CLS) ? C_MAX_CLS : i_num_classifiers;
    assign idx_next      = idx + 1'b1;

`ifdef CASCADE_SAT_EN
    localparam logic signed [SUM_WIDTH-1:0] C_SUM_MAX = {1'b0, {(SUM_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_WIDTH-1:0] C_SUM_MIN = {1'b1, {(SUM_WIDTH-1){1'b0}}};
    logic signed [SUM_WIDTH:0] sum_ext;

    always_comb begin
        sum_ext  = {acc[SUM_WIDTH-1], acc} + {i_weak_value[SUM_WIDTH-1], i_weak_value};
        acc_next = sum_ext[SUM_WIDTH-1:0];
        // Top two bits disagree only on overflow; the top bit gives direction
        if (sum_ext[SUM_WIDTH] != sum_ext[SUM_WIDTH-1]) begin
            acc_next = sum_ext[SUM_WIDTH] ? C_SUM_MIN : C_SUM_MAX;
        end
    end
`else
    assign acc_next = acc + i_weak_value;
`endif

    classifier_param_fetch #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_PARAM  (NUM_PARAM_PER_CLASSIFIER),
        .CNT_W      (CNT_W)
    ) u_fetch (
        .clk         (clk_fpga),
        .rst         (reset_fpga),
        .fetch_en    (fetch_en),
        .base        (base),
        .cls_idx     (idx),
        .rom_address (o_rom_address),
        .rom_q       (i_rom_q),
        .params      (o_params),
        .fetch_last  (fetch_last)
    );

    always_ff @(posedge clk_fpga or posedge reset_fpga) begin
        if (reset_fpga) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    next_state = (count_clamped == '0) ? ST_COMPARE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (fetch_last) begin
                    next_state = ST_WAIT_WEAK;
                end
            end
            ST_WAIT_WEAK: begin
                if (i_weak_valid) begin
                    next_state = (idx_next < count) ? ST_FETCH : ST_COMPARE;
                end
            end
            ST_COMPARE: next_state = ST_DONE;
            ST_DONE:    next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy        = (state != ST_IDLE);
        o_done        = (state == ST_DONE);
        o_param_valid = (state == ST_WAIT_WEAK);
        fetch_en      = (state == ST_FETCH);
    end

    always_ff @(posedge clk_fpga or posedge reset_fpga) begin
        if (reset_fpga) begin
            base   <= '0;
            count  <= '0;
            idx    <= '0;
            thresh <= '0;
            acc    <= '0;
            pass   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        base   <= i_stage_base_addr;
                        count  <= count_clamped;
                        thresh <= i_stage_threshold;
                        idx    <= '0;
                        acc    <= '0;
                        pass   <= 1'b0;
                    end
                end
                ST_WAIT_WEAK: begin
                    if (i_weak_valid) begin
                        acc <= acc_next;
                        idx <= idx_next;
                    end
                end
                ST_COMPARE: pass <= (acc >= thresh);
                default: ;
            endcase
        end
    end

    assign o_pass      = pass;
    assign o_stage_sum = acc;

endmodule

`default_nettype wire
